sram_chip_responder: RTL
========================

// Module: sram_chip_responder
// PURPOSE
// - Clocked, synthesizable model of the external 256Kx16 async SRAM: memory-side responder on the
//   pin interface driven by the SRAM controller (addr, 16-bit inout data, UB/LB/WE/CE/OE, active-low).
// - Replaces the board SRAM for on-chip regression and FPGA builds without the external part.
//   Stores data, honours byte lanes and returns read data after a programmable latency.
// PARAMETERS
// - MEM_AW    8  implemented address bits; SRAM_addr[MEM_AW-1:0] used, upper bits ignored (aliasing)
// - READ_LAT  2  clocks from first sampled read cycle to data valid on SRAM_data; legal 1..7
// PORTS
// - clk           in     1   system clock, all logic on rising edge
// - rst           in     1   synchronous, active-high reset
// - SRAM_addr     in     18  word address from controller
// - SRAM_data     inout  16  data bus; driven only while read data valid, else 16'bz
// - SRAM_UB_N     in     1   upper byte [15:8] enable, active-low
// - SRAM_LB_N     in     1   lower byte [7:0] enable, active-low
// - SRAM_WE_N     in     1   write enable, active-low; dominates OE_N
// - SRAM_CE_N     in     1   chip enable, active-low
// - SRAM_OE_N     in     1   output enable, active-low
// BEHAVIOUR
// - Reset: state=IDLE, lat_cnt=0, rd_q=16'h0000, SRAM_data=16'bz on next cycle; memory NOT cleared.
// - Pins sampled at posedge only. wr_cyc = !CE_N & !WE_N; rd_cyc = !CE_N & WE_N & !OE_N.
// - Write: every edge with wr_cyc writes mem[addr]; [15:8] iff !UB_N, [7:0] iff !LB_N. Both lanes
//   high -> no write. One-cycle write; WE_N held low for N cycles writes N times (idempotent).
// - FSM states IDLE, RD_WAIT, RD_DRIVE:
//   IDLE: rd_cyc -> RD_WAIT, lat_cnt=1, addr_q=addr (READ_LAT=1: straight to RD_DRIVE, rd_q loaded).
//   RD_WAIT: rd_cyc & addr==addr_q -> lat_cnt++; at lat_cnt==READ_LAT-1 load rd_q=mem[addr_q],
//     go RD_DRIVE. Address change -> restart (lat_cnt=1, addr_q=new addr). Not rd_cyc -> IDLE.
//   RD_DRIVE: rd_cyc & same addr -> stay, rd_q reloaded each edge (tracks same-addr writes).
//     Address change -> RD_WAIT restart. Not rd_cyc -> IDLE.
// - Latency: data valid on SRAM_data immediately after the READ_LAT-th consecutive edge sampling
//   rd_cyc at one address (default 2 -> valid within controller's 4-state read window).
// - Drive: lane driven = (state==RD_DRIVE) & !CE_N & WE_N & !OE_N & lane enable, combinational on
//   pins so bus releases in the same cycle WE_N/OE_N/CE_N rise (no contention with write data).
//   Disabled lane = 8'bz.
// - Simultaneous: wr_cyc on an edge -> write performed, FSM -> IDLE, read aborted.
// - Read-after-write same address: read returns new data (write committed before read starts).
// - Reset mid-read: IDLE, bus Z; memory contents retained.
// - X/Z on control pins is a bench error; model treats non-0 as deasserted.
// CONFIGURATION
// - SRAM_STATS_EN defined: adds outputs rd_count[15:0], wr_count[15:0]; rd_count += 1 on each
//   entry into RD_DRIVE, wr_count += 1 on each edge with wr_cyc and at least one lane enabled;
//   both saturate at 16'hFFFF and clear on rst.
// - Not defined: ports and counters absent; all other behaviour identical.
// TESTING
// - Write 0x1234 @0x00005 (UB_N=LB_N=0, 1 cycle) then read @0x00005 -> 0x1234 valid after 2nd edge.
// - Byte lanes: write 0xAAAA @7, then 0x5511 with UB_N=1 -> read returns 0xAA11; read with
//   LB_N=1 -> [7:0]=Z, [15:8]=0xAA.
// - Alias: write 0xBEEF @0x00103 (MEM_AW=8) -> read @0x00003 returns 0xBEEF.
// - Addr change mid-RD_WAIT (READ_LAT=3): @1 one edge, then @2 -> data of @2 after 3 more edges.
// - WE_N low while RD_DRIVE: bus Z same cycle, write lands, state IDLE next edge.
// - rst asserted in RD_DRIVE -> bus Z next cycle; later read of same addr returns pre-reset data.

Source files
------------

// File: rtl/sram_chip_responder.sv
// Clocked stand-in for the external 256Kx16 async SRAM, answering the controller's pin interface.
// Optional build macro SRAM_STATS_EN adds saturating read/write event counters.
module sram_chip_responder #(
  parameter int MEM_AW   = 8,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SRAM_addr,
  inout  wire  [15:0] SRAM_data,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N
`ifdef SRAM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE} StateT;

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  StateT       r_state, w_stateNext;
  logic [2:0]  r_latCnt, w_latCntNext;
  logic [17:0] r_addrQ, w_addrQNext;
  logic [15:0] r_rdQ, w_rdQNext;
  logic [15:0] r_mem [0:(1<<MEM_AW)-1];

  logic              w_wrCyc;
  logic              w_rdCyc;
  logic              w_sameAddr;
  logic              w_driveBase;
  logic [MEM_AW-1:0] w_memIdx;
  logic [15:0]       w_memWord;

  assign w_wrCyc    = ~SRAM_CE_N & ~SRAM_WE_N;
  assign w_rdCyc    = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
  assign w_sameAddr = (SRAM_addr == r_addrQ);
  assign w_memIdx   = SRAM_addr[MEM_AW-1:0];
  assign w_memWord  = r_mem[w_memIdx];

  // Memory has no reset so its contents survive rst, like the real part.
  always_ff @(posedge clk) begin
    if (w_wrCyc) begin
      if (!SRAM_UB_N) r_mem[w_memIdx][15:8] <= SRAM_data[15:8];
      if (!SRAM_LB_N) r_mem[w_memIdx][7:0]  <= SRAM_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_latCnt <= 3'd0;
      r_addrQ  <= 18'd0;
      r_rdQ    <= 16'h0000;
    end else begin
      r_state  <= w_stateNext;
      r_latCnt <= w_latCntNext;
      r_addrQ  <= w_addrQNext;
      r_rdQ    <= w_rdQNext;
    end
  end

  // Reads load from the pin address; it equals r_addrQ whenever a same-address reload happens.
  always_comb begin
    w_stateNext  = r_state;
    w_latCntNext = r_latCnt;
    w_addrQNext  = r_addrQ;
    w_rdQNext    = r_rdQ;
    if (w_wrCyc) begin
      w_stateNext  = IDLE;
      w_latCntNext = 3'd0;
    end else if (!w_rdCyc) begin
      w_stateNext  = IDLE;
      w_latCntNext = 3'd0;
    end else if (r_state == IDLE || !w_sameAddr) begin
      w_addrQNext  = SRAM_addr;
      w_latCntNext = 3'd1;
      if (READ_LAT == 1) begin
        w_stateNext = RD_DRIVE;
        w_rdQNext   = w_memWord;
      end else begin
        w_stateNext = RD_WAIT;
      end
    end else if (r_state == RD_WAIT) begin
      w_latCntNext = r_latCnt + 3'd1;
      if (r_latCnt == LAT_LAST) begin
        w_stateNext = RD_DRIVE;
        w_rdQNext   = w_memWord;
      end
    end else begin
      w_rdQNext = w_memWord;
    end
  end

  // Drive gating is combinational on the pins so the bus frees in the cycle WE_N/OE_N/CE_N rise.
  assign w_driveBase     = (r_state == RD_DRIVE) & ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
  assign SRAM_data[15:8] = (w_driveBase & ~SRAM_UB_N) ? r_rdQ[15:8] : 8'bz;
  assign SRAM_data[7:0]  = (w_driveBase & ~SRAM_LB_N) ? r_rdQ[7:0]  : 8'bz;

`ifdef SRAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else begin
      if (w_stateNext == RD_DRIVE && r_state != RD_DRIVE && rd_count != 16'hFFFF)
        rd_count <= rd_count + 16'h0001;
      if (w_wrCyc && (!SRAM_UB_N || !SRAM_LB_N) && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'h0001;
    end
  end
`endif

endmodule
